ex_div_unit: RTL and testbench
==============================

// Module: ex_div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider in the EX stage. It performs DIV/DIVU and
//  drives stallreq_for_ex into CTRL while a quotient is pending, which freezes IF..EX.
//  When done, it returns quotient (to LO) and remainder (to HI) with a 1-cycle valid.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  CNT_W  6   iteration counter width; must hold WIDTH
// PORTS
//  clk              input   1      rising-edge clock
//  rst              input   1      asynchronous active-low reset (0 = reset)
//  div_start        input   1      DIV/DIVU instruction in EX; held high until result_valid
//  div_signed       input   1      1 = DIV (signed), 0 = DIVU; sampled with div_start
//  annul            input   1      flush: abort any division, return to IDLE
//  dividend         input   WIDTH  rs operand; sampled on accept
//  divisor          input   WIDTH  rt operand; sampled on accept
//  stallreq_for_ex  output  1      stall request to CTRL (combinational)
//  result_valid     output  1      quotient/remainder valid; 1-cycle pulse
//  quotient         output  WIDTH  to LO; holds its value until the next accept
//  remainder        output  WIDTH  to HI; holds its value until the next accept
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0, all datapath regs=0, result_valid=0,
//    quotient=0, remainder=0, stallreq_for_ex=0.
//  FSM states: IDLE, BUSY, DIVZERO, DONE.
//   IDLE: if div_start && !annul, accept the operands (latch them and div_signed).
//         If divisor==0, go to DIVZERO; otherwise go to BUSY with counter=0.
//   BUSY: perform one restoring step per cycle on |dividend| and |divisor|.
//         After WIDTH steps (counter==WIDTH-1), go to DONE.
//   DIVZERO: go to DONE.
//   DONE: result_valid=1 and quotient/remainder are registered. Always go to IDLE,
//         even if div_start is still high (the instruction leaves EX this cycle).
//  stallreq_for_ex = (IDLE && div_start && !annul) || BUSY || DIVZERO.
//    It is 0 in DONE, so the pipeline advances exactly on the result cycle.
//  Latency: accept at cycle N, DONE at N+WIDTH+1 (33 stall cycles for WIDTH=32).
//    For divide-by-zero, DONE is at N+2.
//  Signed mode: divide the magnitudes.
//    Quotient is negated if sign(dividend)!=sign(divisor).
//    Remainder takes the sign of the dividend.
//    -2^31 / -1: quotient=32'h8000_0000, remainder=0 (two's-complement wrap, no trap).
//    Magnitude of -2^31 is computed as an unsigned WIDTH-bit value, with no overflow.
//  Divide-by-zero: quotient={WIDTH{1'b1}} and remainder=dividend, in both modes.
//  annul=1 in any state: next state=IDLE, result_valid=0, and quotient/remainder
//    keep their old values. annul has priority over div_start and over DONE.
//  Operand inputs are ignored outside the accept cycle, so mid-divide changes have no effect.
//  Reset asserted mid-operation: immediate IDLE, with no residual stall or valid.
// TESTING
//  1) DIVU 100/7 -> stallreq high for 33 cycles; then result_valid=1 for one cycle
//     with quotient=14, remainder=2; then IDLE.
//  2) DIV -7/2 -> quotient=32'hFFFF_FFFD (-3), remainder=32'hFFFF_FFFF (-1).
//     DIV 7/-2 -> quotient=-3, remainder=1.
//  3) DIV 32'h8000_0000 / 32'hFFFF_FFFF -> quotient=32'h8000_0000, remainder=0.
//     DIVU 32'hFFFF_FFFF/1 -> quotient=32'hFFFF_FFFF, remainder=0.
//  4) Divisor=0 with dividend=5 -> stallreq for 2 cycles; then valid with
//     quotient=32'hFFFF_FFFF, remainder=5.
//  5) annul at BUSY step 10 -> stallreq=0 the next cycle, no result_valid,
//     prior quotient/remainder unchanged. A new div_start then runs a full 33 cycles.
//  6) div_start held through DONE -> exactly one result_valid and no restart.
//     rst=0 pulse mid-BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle radix-2 restoring divider for the EX stage.
// Handles DIV (signed) and DIVU, stalls IF..EX while a quotient is pending and
// returns quotient (LO) and remainder (HI) with a single-cycle valid.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for div_start; operands latched on accept
//   S_BUSY    | one restoring step per cycle on operand magnitudes
//   S_DIVZERO | divisor was zero; fixed result staged, no iterations
//   S_DONE    | result_valid high for one cycle, pipeline advances
module ex_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_start,
   input  logic             div_signed,
   input  logic             annul,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             stallreq_for_ex,
   output logic             result_valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_DIVZERO = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // dvd_q shifts the dividend magnitude out at the top while quotient bits
   // enter at the bottom, so after WIDTH steps it holds the raw quotient.
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic [WIDTH-1:0]   quotient_q, quotient_d;
   logic [WIDTH-1:0]   remainder_q, remainder_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     rem_shift;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_step, dvd_step;
   logic [WIDTH-1:0]   q_res, r_res;

   // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is the correct
   // unsigned magnitude.
   always_comb begin
      a_neg = div_signed & dividend[WIDTH-1];
      b_neg = div_signed & divisor[WIDTH-1];
      a_mag = a_neg ? (WIDTH'(0) - dividend) : dividend;
      b_mag = b_neg ? (WIDTH'(0) - divisor)  : divisor;
   end

   // One restoring step plus sign fix-up of the would-be final result.
   // The partial remainder stays below the divisor, so the subtraction
   // result always fits in WIDTH bits.
   always_comb begin
      rem_shift = {rem_q, dvd_q[WIDTH-1]};
      q_bit     = (rem_shift >= {1'b0, dvs_q});
      rem_step  = q_bit ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
      dvd_step  = {dvd_q[WIDTH-2:0], q_bit};
      q_res     = q_neg_q ? (WIDTH'(0) - dvd_step) : dvd_step;
      r_res     = r_neg_q ? (WIDTH'(0) - rem_step) : rem_step;
   end

   // Next-state and datapath update; annul overrides everything at the end.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      case (state_q)
         S_IDLE: begin
            if (div_start) begin
               cnt_d = '0;
               if (divisor == '0) begin
                  // Staged so S_DIVZERO can load the outputs directly.
                  dvd_d   = '1;
                  dvs_d   = '0;
                  rem_d   = dividend;
                  q_neg_d = 1'b0;
                  r_neg_d = 1'b0;
                  state_d = S_DIVZERO;
               end else begin
                  dvd_d   = a_mag;
                  dvs_d   = b_mag;
                  rem_d   = '0;
                  q_neg_d = a_neg ^ b_neg;
                  r_neg_d = a_neg;
                  state_d = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            dvd_d = dvd_step;
            rem_d = rem_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               quotient_d  = q_res;
               remainder_d = r_res;
               state_d     = S_DONE;
            end
         end
         S_DIVZERO: begin
            quotient_d  = dvd_q;
            remainder_d = rem_q;
            state_d     = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (annul) begin
         state_d     = S_IDLE;
         dvd_d       = dvd_q;
         dvs_d       = dvs_q;
         rem_d       = rem_q;
         q_neg_d     = q_neg_q;
         r_neg_d     = r_neg_q;
         cnt_d       = cnt_q;
         quotient_d  = quotient_q;
         remainder_d = remainder_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   // Stall is combinational so CTRL freezes the pipe on the accept cycle;
   // gating with rst keeps it low while reset is held.
   always_comb begin
      stallreq_for_ex = rst & (((state_q == S_IDLE) & div_start & ~annul) |
                               (state_q == S_BUSY) | (state_q == S_DIVZERO));
      result_valid    = (state_q == S_DONE) & ~annul;
      quotient        = quotient_q;
      remainder       = remainder_q;
   end

endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: the driver queues expected results as it
// issues divisions, an independent monitor checks every result_valid pulse.
module tb_ex_div_unit;

   logic        clk;
   logic        rst;
   logic        div_start;
   logic        div_signed;
   logic        annul;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        stallreq_for_ex;
   logic        result_valid;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp_q_fifo[$];
   logic [31:0] exp_r_fifo[$];
   logic [31:0] last_q, last_r;

   ex_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .div_start       (div_start),
      .div_signed      (div_signed),
      .annul           (annul),
      .dividend        (dividend),
      .divisor         (divisor),
      .stallreq_for_ex (stallreq_for_ex),
      .result_valid    (result_valid),
      .quotient        (quotient),
      .remainder       (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every valid pulse must match the head of the scoreboard.
   initial begin
      logic [31:0] eq, er;
      forever begin
         @(negedge clk);
         if (result_valid === 1'b1) begin
            n_cmp++;
            if (exp_q_fifo.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_valid: got q=%h r=%h with nothing pending", quotient, remainder);
            end else begin
               eq = exp_q_fifo.pop_front();
               er = exp_r_fifo.pop_front();
               check("quotient", quotient, eq);
               check("remainder", remainder, er);
            end
         end
      end
   end

   // Issue one division, hold div_start through DONE, count stall cycles.
   // Operands are scrambled mid-divide to show they are ignored after accept.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int exp_stall,
                          input string name);
      int stalls = 0;
      int cyc = 0;
      bit seen = 0;
      exp_q_fifo.push_back(eq);
      exp_r_fifo.push_back(er);
      @(posedge clk); #1;
      div_signed = sgn; dividend = a; divisor = b; div_start = 1'b1;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (stallreq_for_ex) stalls++;
         if (result_valid) seen = 1;
         if (cyc == 3) begin
            dividend = ~a;
            divisor  = b + 32'd5;
            div_signed = ~sgn;
         end
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s_timeout: no result_valid after %0d cycles", name, cyc);
      end
      check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
      @(posedge clk); #1;
      div_start = 1'b0;
      @(negedge clk);
      check({name, "_stall_after"}, {31'd0, stallreq_for_ex}, 32'd0);
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      rst = 1'b0; div_start = 1'b0; div_signed = 1'b0; annul = 1'b0;
      dividend = '0; divisor = '0;
      last_q = '0; last_r = '0;
      #23;
      check("reset_stall", {31'd0, stallreq_for_ex}, 32'd0);
      check("reset_valid", {31'd0, result_valid}, 32'd0);
      check("reset_quotient", quotient, 32'd0);
      check("reset_remainder", remainder, 32'd0);
      @(posedge clk); #1; rst = 1'b1;

      run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_100_7");
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, "div_7_m2");
      run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 33, "div_m100_m7");
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, "div_min_m1");
      run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, "divu_max_1");
      run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 33, "divu_max_maxm1");
      run_div(1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 33, "divu_3_10");
      run_div(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2, "divu_5_0");
      run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 2, "div_m5_0");

      // annul together with div_start in IDLE: nothing accepted, no stall
      @(posedge clk); #1;
      div_signed = 1'b0; dividend = 32'd9; divisor = 32'd3; div_start = 1'b1; annul = 1'b1;
      @(negedge clk);
      check("annul_idle_stall", {31'd0, stallreq_for_ex}, 32'd0);
      @(posedge clk); #1;
      div_start = 1'b0; annul = 1'b0;
      @(negedge clk);
      check("annul_idle_after", {31'd0, stallreq_for_ex}, 32'd0);

      // annul at BUSY step 10
      @(posedge clk); #1;
      div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; div_start = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      annul = 1'b1; div_start = 1'b0;
      @(posedge clk); #1;
      annul = 1'b0;
      @(negedge clk);
      check("annul_busy_stall", {31'd0, stallreq_for_ex}, 32'd0);
      check("annul_busy_quotient", quotient, last_q);
      check("annul_busy_remainder", remainder, last_r);
      repeat (40) @(negedge clk);
      run_div(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, "divu_after_annul");

      // reset pulse mid-BUSY with div_start still high
      @(posedge clk); #1;
      div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("rst_mid_stall", {31'd0, stallreq_for_ex}, 32'd0);
      check("rst_mid_valid", {31'd0, result_valid}, 32'd0);
      check("rst_mid_quotient", quotient, 32'd0);
      check("rst_mid_remainder", remainder, 32'd0);
      div_start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check("rst_after_stall", {31'd0, stallreq_for_ex}, 32'd0);
      run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "divu_after_rst");

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q_fifo.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
